// File: rtl/cmd_exec_burst_if.sv
// cmd_exec_burst_if: byte-stream handshake between the RX byte FIFO, the
// command executor and the TX response FIFO.
//   byte_fifo_valid/data  RX FIFO head (first-word-fall-through)
//   byte_fifo_rd_en       pop RX FIFO head this cycle
//   cmd_resp_full         TX FIFO full
//   cmd_resp_wr_data/en   push one response byte this cycle
// slave  = executor side, master = FIFO/environment side.
interface cmd_exec_burst_if;
  logic       byte_fifo_valid;
  logic [7:0] byte_fifo_data;
  logic       byte_fifo_rd_en;
  logic       cmd_resp_full;
  logic [7:0] cmd_resp_wr_data;
  logic       cmd_resp_wr_en;

  modport slave (
    input  byte_fifo_valid, byte_fifo_data, cmd_resp_full,
    output byte_fifo_rd_en, cmd_resp_wr_data, cmd_resp_wr_en
  );
  modport master (
    output byte_fifo_valid, byte_fifo_data, cmd_resp_full,
    input  byte_fifo_rd_en, cmd_resp_wr_data, cmd_resp_wr_en
  );
endinterface

// File: rtl/cmd_exec_burst.sv
// cmd_exec_burst: parses framed burst read/write commands from the RX byte
// stream, executes them against an internal register bank and emits response
// bytes into the TX FIFO, honouring TX backpressure.
// Frame: OP | ADDR (ADDR_BYTES, MSB first) | LEN | [WDATA (LEN+1)*DATA_BYTES]
//   0x57 write -> A5 ack, 0x52 read -> 5A + data, error -> EE.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       cmd_exec_burst_if.slave (RX pop / TX push handshake)
//   busy      high whenever the FSM is not idle in S_OP
// Optional: define CMD_EXEC_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES idle cycles while waiting for frame bytes.
module cmd_exec_burst #(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 4,
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  cmd_exec_burst_if.slave        bus,
  output logic                   busy
);
  localparam int AW = ADDR_BYTES * 8;
  localparam int DW = DATA_BYTES * 8;
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

  localparam logic [7:0] OP_WR = 8'h57, OP_RD = 8'h52;
  localparam logic [7:0] RSP_WACK = 8'hA5, RSP_RHDR = 8'h5A, RSP_ERR = 8'hEE;

  typedef enum logic [3:0] {
    S_OP, S_ADDR, S_LEN, S_WDATA, S_DRAIN, S_WACK, S_RHDR, S_RDATA, S_ERR
  } state_t;

  state_t          state, nstate;
  logic            op_wr;
  logic [AW-1:0]   addr;
  logic [CW-1:0]   acnt;
  logic [7:0]      len;
  logic [7:0]      wcnt;
  logic [BW-1:0]   bcnt;
  logic [DW-1:0]   wsh, rsh;
  logic [DW-1:0]   regs [NUM_REGS];

  logic            consume, resp_st, pop, push, tmo;
  logic            last_addr, last_byte, last_word, in_range;
  logic [AW+7:0]   addr_cat;
  logic [DW+7:0]   wcat;
  logic [AW:0]     sum;
  logic [IW-1:0]   aidx;
  logic [DW-1:0]   rword;

  assign consume   = state inside {S_OP, S_ADDR, S_LEN, S_WDATA, S_DRAIN};
  assign resp_st   = state inside {S_WACK, S_RHDR, S_RDATA, S_ERR};
  assign pop       = bus.byte_fifo_rd_en;
  assign push      = bus.cmd_resp_wr_en;
  assign last_addr = acnt == CW'(ADDR_BYTES - 1);
  assign last_byte = bcnt == BW'(DATA_BYTES - 1);
  assign last_word = wcnt == len;
  assign addr_cat  = {addr, bus.byte_fifo_data};
  assign wcat      = {wsh, bus.byte_fifo_data};
  // One extra bit so addr+LEN cannot wrap past the end of the bank.
  assign sum       = {1'b0, addr} + (AW+1)'(bus.byte_fifo_data);
  assign in_range  = sum < (AW+1)'(NUM_REGS);
  assign aidx      = addr[IW-1:0];
  assign rword     = regs[aidx];

`ifdef CMD_EXEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          wait_st;
  assign wait_st = state inside {S_ADDR, S_LEN, S_WDATA, S_DRAIN};
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tcnt <= '0;
    else if (!wait_st || pop)  tcnt <= '0;
    else if (!bus.byte_fifo_valid) tcnt <= tcnt + 1'b1;
  end
  // Fires on the TIMEOUT_CYCLES-th consecutive starved cycle.
  assign tmo = wait_st && !bus.byte_fifo_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OP;
    else     state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    case (state)
      S_OP:    if (pop) nstate = (bus.byte_fifo_data == OP_WR || bus.byte_fifo_data == OP_RD)
                                 ? S_ADDR : S_ERR;
      S_ADDR:  if (pop && last_addr) nstate = S_LEN;
      S_LEN:   if (pop) begin
                 if (op_wr) nstate = in_range ? S_WDATA : S_DRAIN;
                 else       nstate = in_range ? S_RHDR  : S_ERR;
               end
      S_WDATA: if (pop && last_byte && last_word) nstate = S_WACK;
      S_DRAIN: if (pop && last_byte && last_word) nstate = S_ERR;
      S_WACK:  if (push) nstate = S_OP;
      S_RHDR:  if (push) nstate = S_RDATA;
      S_RDATA: if (push && last_byte && last_word) nstate = S_OP;
      S_ERR:   if (push) nstate = S_OP;
      default: nstate = S_OP;
    endcase
    if (tmo) nstate = S_ERR;
  end

  // Output logic
  always_comb begin
    bus.byte_fifo_rd_en  = consume && bus.byte_fifo_valid && !rst;
    bus.cmd_resp_wr_en   = resp_st && !bus.cmd_resp_full;
    bus.cmd_resp_wr_data = 8'h00;
    busy                 = state != S_OP;
    case (state)
      S_WACK:  bus.cmd_resp_wr_data = RSP_WACK;
      S_RHDR:  bus.cmd_resp_wr_data = RSP_RHDR;
      S_ERR:   bus.cmd_resp_wr_data = RSP_ERR;
      // First byte comes straight from the bank; the rest from the shifter.
      S_RDATA: bus.cmd_resp_wr_data = (bcnt == '0) ? rword[DW-1 -: 8] : rsh[DW-1 -: 8];
      default: ;
    endcase
  end

  // Datapath: address/length capture, word assembly, register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr <= 1'b0;
      addr  <= '0;
      acnt  <= '0;
      len   <= '0;
      wcnt  <= '0;
      bcnt  <= '0;
      wsh   <= '0;
      rsh   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_OP: if (pop) begin
          op_wr <= bus.byte_fifo_data == OP_WR;
          addr  <= '0;
          acnt  <= '0;
        end
        S_ADDR: if (pop) begin
          addr <= addr_cat[AW-1:0];
          acnt <= acnt + 1'b1;
        end
        S_LEN: if (pop) begin
          len  <= bus.byte_fifo_data;
          wcnt <= '0;
          bcnt <= '0;
        end
        S_WDATA, S_DRAIN: if (pop) begin
          wsh <= wcat[DW-1:0];
          if (last_byte) begin
            if (state == S_WDATA) regs[aidx] <= wcat[DW-1:0];
            bcnt <= '0;
            wcnt <= wcnt + 1'b1;
            addr <= addr + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        S_RDATA: if (push) begin
          rsh <= ((bcnt == '0) ? rword : rsh) << 8;
          if (last_byte) begin
            bcnt <= '0;
            wcnt <= wcnt + 1'b1;
            addr <= addr + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_exec_burst.sv
// Directed bench for cmd_exec_burst (ADDR_BYTES=1, DATA_BYTES=4, NUM_REGS=16,
// TIMEOUT_CYCLES=50). A queue models the FWFT RX FIFO, another collects the
// pushed response bytes; each frame's response is compared against a
// hand-built expected byte list.
module tb_cmd_exec_burst;
  logic clk = 1'b0;
  logic rst;
  logic busy;

  cmd_exec_burst_if ifc ();

  cmd_exec_burst #(
    .ADDR_BYTES(1), .DATA_BYTES(4), .NUM_REGS(16), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] resp[$];
  logic [7:0] exq[$];
  int passes = 0, total = 0;
  int npops = 0, pop_empty = 0, full_viol = 0;
  logic m_pop, m_wr, m_full;
  logic [7:0] m_data;

  // FIFO model: sample handshakes at the edge, apply them just after.
  always @(posedge clk) begin
    m_pop  = ifc.byte_fifo_rd_en;
    m_wr   = ifc.cmd_resp_wr_en;
    m_full = ifc.cmd_resp_full;
    m_data = ifc.cmd_resp_wr_data;
    #1;
    if (m_pop) begin
      if (rxq.size() == 0) pop_empty++;
      else void'(rxq.pop_front());
      npops++;
    end
    if (m_wr) begin
      if (m_full) full_viol++;
      resp.push_back(m_data);
    end
  end

  always @(negedge clk) begin
    ifc.byte_fifo_valid = rxq.size() != 0;
    ifc.byte_fifo_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tx(input logic [7:0] b);
    rxq.push_back(b);
  endtask
  task automatic txw(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) rxq.push_back(w[i*8 +: 8]);
  endtask
  task automatic ex(input logic [7:0] b);
    exq.push_back(b);
  endtask
  task automatic exw(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exq.push_back(w[i*8 +: 8]);
  endtask

  // Wait (bounded) for the expected number of bytes, linger to catch extras,
  // then compare count and every byte.
  task automatic expect_resp(input string tag);
    int c = 0;
    int n = exq.size();
    while (resp.size() < n && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, "_cnt"}, 64'(resp.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), (i < resp.size()) ? 64'(resp[i]) : 64'hx, 64'(exq[i]));
    resp.delete();
    exq.delete();
  endtask

  task automatic wait_rx_empty();
    int c = 0;
    while (rxq.size() != 0 && c < 500) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
  endtask

  initial begin
    int p0;
    int c;
    rst = 1'b1;
    ifc.cmd_resp_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", ifc.byte_fifo_rd_en, 0);
    check("rst_wr_en", ifc.cmd_resp_wr_en, 0);
    check("rst_wr_data", ifc.cmd_resp_wr_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single-word write, then read back the whole bank.
    tx(8'h57); tx(8'h03); tx(8'h00); txw(32'hDEADBEEF);
    ex(8'hA5);
    expect_resp("wr1");
    tx(8'h52); tx(8'h00); tx(8'h0F);
    ex(8'h5A);
    for (int i = 0; i < 16; i++) exw((i == 3) ? 32'hDEADBEEF : 32'h0);
    expect_resp("rdall");

    // Burst write then burst read.
    tx(8'h57); tx(8'h04); tx(8'h01); txw(32'h11111111); txw(32'h22222222);
    ex(8'hA5);
    expect_resp("bwr");
    tx(8'h52); tx(8'h04); tx(8'h01);
    ex(8'h5A); exw(32'h11111111); exw(32'h22222222);
    expect_resp("brd");

    // Out-of-range write: payload drained, nothing written.
    p0 = npops;
    tx(8'h57); tx(8'h0F); tx(8'h01); txw(32'hCAFEF00D); txw(32'h12345678);
    ex(8'hEE);
    expect_resp("oor");
    check("oor_pops", 64'(npops - p0), 64'd11);
    check("oor_rx_left", 64'(rxq.size()), 0);
    tx(8'h52); tx(8'h0F); tx(8'h00);
    ex(8'h5A); exw(32'h0);
    expect_resp("rd15");

    // Out-of-range read and bad opcode, each followed by a valid read.
    tx(8'h52); tx(8'h0E); tx(8'h02);
    ex(8'hEE);
    expect_resp("oor_rd");
    tx(8'h33);
    ex(8'hEE);
    expect_resp("badop");
    tx(8'h52); tx(8'h03); tx(8'h00);
    ex(8'h5A); exw(32'hDEADBEEF);
    expect_resp("rd3");

    // Backpressure: full for 20 cycles, then a mid-stream stall.
    ifc.cmd_resp_full = 1'b1;
    tx(8'h52); tx(8'h04); tx(8'h01);
    repeat (20) @(negedge clk);
    check("bp_held_cnt", 64'(resp.size()), 0);
    check("bp_busy", busy, 1);
    ifc.cmd_resp_full = 1'b0;
    c = 0;
    while (resp.size() < 3 && c < 100) begin
      @(negedge clk);
      c++;
    end
    ifc.cmd_resp_full = 1'b1;
    repeat (5) @(negedge clk);
    ifc.cmd_resp_full = 1'b0;
    ex(8'h5A); exw(32'h11111111); exw(32'h22222222);
    expect_resp("bp");

    // Starved frame: abandoned by timeout if enabled, otherwise completed later.
    tx(8'h57); tx(8'h02);
`ifdef CMD_EXEC_TIMEOUT_EN
    ex(8'hEE);
    expect_resp("tmo");
    check("tmo_busy", busy, 0);
    tx(8'h57); tx(8'h02);
`else
    repeat (200) @(negedge clk);
    check("stall_cnt", 64'(resp.size()), 0);
    check("stall_busy", busy, 1);
`endif
    tx(8'h00); txw(32'h01020304);
    ex(8'hA5);
    expect_resp("wr2");
    tx(8'h52); tx(8'h02); tx(8'h00);
    ex(8'h5A); exw(32'h01020304);
    expect_resp("rd2");

    // Reset mid-burst: partial frame dropped, bank cleared.
    tx(8'h57); tx(8'h05); tx(8'h01); tx(8'hAA); tx(8'hBB);
    wait_rx_empty();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", ifc.byte_fifo_rd_en, 0);
    check("mid_rst_wr_en", ifc.cmd_resp_wr_en, 0);
    check("mid_rst_wr_data", ifc.cmd_resp_wr_data, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx(8'h52); tx(8'h03); tx(8'h00);
    ex(8'h5A); exw(32'h0);
    expect_resp("post_rst");

    check("full_violations", 64'(full_viol), 0);
    check("pop_on_empty", 64'(pop_empty), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
